// File: rtl/exu_mdu_seq.sv
// Iterative radix-2 multiply / divide / remainder sequencer for the EXU (unsigned ALUop 2, 3, 10).
// One operand bit is processed per clock: shift-add multiply (LSB first), restoring divide (MSB first).
//
// state  | meaning
// IDLE   | waiting for an op; in_ready high
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | result presented on out_*; waits for out_ready
module exu_mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [4:0]      out_rd,
    output logic            out_dz,
    output logic            out_ill,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    // MUL: opnd_q = shifted multiplicand, shf_q = shifted multiplier.
    // DIV: opnd_q = divisor, shf_q = dividend shifting out / quotient shifting in.
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   shf_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   rem_q;
    logic              is_rem_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        rd_q;
    logic              dz_q;
    logic              ill_q;

    logic              accept;
    logic              last_step;
    logic              op_mul;
    logic              op_div;
    logic              op_rem;
    logic [XLEN-1:0]   acc_d;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;

    assign op_mul    = (in_op == 4'd2);
    assign op_div    = (in_op == 4'd3);
    assign op_rem    = (in_op == 4'd10);
    assign accept    = in_valid & (state_q == S_IDLE) & ~kill;
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    assign acc_d     = acc_q + (shf_q[0] ? opnd_q : '0);

    // The extra top bit of the trial subtraction is the borrow: set means divisor did not fit.
    assign div_shift = {rem_q, shf_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[XLEN];
    assign rem_d     = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quo_d     = {shf_q[XLEN-2:0], div_ok};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            shf_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
            res_q    <= '0;
            rd_q     <= '0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        dz_q     <= 1'b0;
                        ill_q    <= 1'b0;
                        rd_q     <= in_rd;
                        is_rem_q <= op_rem;
                        acc_q    <= '0;
                        rem_q    <= '0;
                        if (op_mul) begin
                            opnd_q  <= in_a;
                            shf_q   <= in_b;
                            state_q <= S_MUL;
                        end else if (op_div || op_rem) begin
                            opnd_q <= in_b;
                            shf_q  <= in_a;
                            if (in_b == '0) begin
                                res_q   <= op_rem ? in_a : '1;
                                dz_q    <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_DIV;
                            end
                        end else begin
                            res_q   <= '0;
                            ill_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q  <= acc_d;
                        opnd_q <= opnd_q << 1;
                        shf_q  <= shf_q >> 1;
                        if (last_step) begin
                            res_q   <= acc_d;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DIV: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        shf_q <= quo_d;
                        if (last_step) begin
                            res_q   <= is_rem_q ? rem_d : quo_d;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready || kill) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_res   = res_q;
    assign out_rd    = rd_q;
    assign out_dz    = dz_q;
    assign out_ill   = ill_q;

endmodule

// File: tb/tb_exu_mdu_seq.sv
// Directed bench for exu_mdu_seq: expected results are queued at issue and popped when out_valid rises.
module tb_exu_mdu_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd;
    logic            out_dz;
    logic            out_ill;
    logic            busy;

    exu_mdu_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_rd    (out_rd),
        .out_dz    (out_dz),
        .out_ill   (out_ill),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        logic            dz;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [4:0] rd);
        exp_t e;
        e.rd  = rd;
        e.dz  = 1'b0;
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            4'd2:  e.res = a * b;
            4'd3:  begin
                if (b == 0) begin e.res = '1; e.dz = 1'b1; end
                else e.res = a / b;
            end
            4'd10: begin
                if (b == 0) begin e.res = a; e.dz = 1'b1; end
                else e.res = a % b;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] rd);
        chk("in_ready_before_issue", XLEN'(in_ready), 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat = number of edges after the accept edge before out_valid is seen high.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd,
                          input int lat, input int hold);
        exp_t e;
        int   n;
        sb.push_back(model(op, a, b, rd));
        out_ready = (hold == 0);
        drive(op, a, b, rd);
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == 1) begin
                chk({tag, "_busy"}, XLEN'(busy), 1);
                chk({tag, "_in_ready_low"}, XLEN'(in_ready), 0);
            end
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, XLEN'(n), XLEN'(lat));
        e = sb.pop_front();
        chk({tag, "_res"}, out_res, e.res);
        chk({tag, "_rd"}, XLEN'(out_rd), XLEN'(e.rd));
        chk({tag, "_dz"}, XLEN'(out_dz), XLEN'(e.dz));
        chk({tag, "_ill"}, XLEN'(out_ill), XLEN'(e.ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, XLEN'(out_valid), 1);
            chk({tag, "_hold_res"}, out_res, e.res);
            chk({tag, "_hold_rd"}, XLEN'(out_rd), XLEN'(e.rd));
            chk({tag, "_hold_in_ready"}, XLEN'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_drained"}, XLEN'(out_valid), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, XLEN'(in_ready), 1);
        chk({tag, "_out_valid"}, XLEN'(out_valid), 0);
        chk({tag, "_busy"}, XLEN'(busy), 0);
        chk({tag, "_out_res"}, out_res, 0);
        chk({tag, "_out_rd"}, XLEN'(out_rd), 0);
        chk({tag, "_out_dz"}, XLEN'(out_dz), 0);
        chk({tag, "_out_ill"}, XLEN'(out_ill), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]      rop;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        kill      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7x6", 4'd2, 32'd7, 32'd6, 5'd1, 32, 0);
        run_op("div_100_7", 4'd3, 32'd100, 32'd7, 5'd2, 32, 0);
        run_op("rem_100_7", 4'd10, 32'd100, 32'd7, 5'd3, 32, 0);
        run_op("div_5_0", 4'd3, 32'd5, 32'd0, 5'd4, 0, 0);
        run_op("rem_5_0", 4'd10, 32'd5, 32'd0, 5'd5, 0, 0);
        run_op("mul_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32, 5);
        run_op("div_max_1", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd7, 32, 0);
        run_op("rem_small", 4'd10, 32'd3, 32'hFFFF_FFFF, 5'd8, 32, 0);

        for (int i = 0; i < 6; i++) begin
            rop = (i % 3 == 0) ? 4'd2 : ((i % 3 == 1) ? 4'd3 : 4'd10);
            ra  = $urandom;
            rb  = (i < 3) ? $urandom : XLEN'($urandom_range(1, 1000));
            run_op("rand", rop, ra, rb, 5'(i + 10), (rop != 4'd2 && rb == 0) ? 0 : 32, i % 2);
        end

        // Flush mid-divide: back to IDLE at the next edge, result lost.
        drive(4'd3, 32'd1000, 32'd3, 5'd20);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_out_valid", XLEN'(out_valid), 0);
        chk("kill_busy", XLEN'(busy), 0);
        chk("kill_in_ready", XLEN'(in_ready), 1);
        repeat (30) @(negedge clk);
        chk("kill_no_late_result", XLEN'(out_valid), 0);

        // kill with in_valid in IDLE must not accept.
        in_valid = 1'b1;
        kill     = 1'b1;
        in_op    = 4'd2;
        in_a     = 32'd9;
        in_b     = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        chk("kill_idle_no_accept", XLEN'(busy), 0);

        run_op("mul_3x3", 4'd2, 32'd3, 32'd3, 5'd21, 32, 0);
        run_op("ill_op_15", 4'd15, 32'd11, 32'd12, 5'd22, 0, 0);

        // Synchronous reset mid-multiply discards the op and clears outputs.
        drive(4'd2, 32'd5, 32'd5, 5'd23);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset_mid_mul");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("ill_op_4", 4'd4, 32'd7, 32'd7, 5'd24, 0, 0);
        run_op("mul_after", 4'd2, 32'd12345, 32'd678, 5'd25, 32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
